// File: rtl/switch_cfg_pkg.sv
// ---------------------------------------------------------------------------
// switch_cfg_pkg
// Shared types and constants for the switch memory-config arbiter:
// FSM state encoding, address/data widths, default requester count and
// timeout, and an index-width helper that stays >= 1 for degenerate sizes.
// ---------------------------------------------------------------------------
package switch_cfg_pkg;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int NUM_REQ_DEF = 4;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Width of an index into n items; a single item still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_rr_picker.sv
// ---------------------------------------------------------------------------
// cfg_rr_picker
// Combinational round-robin winner search. Scans the request vector starting
// at rr_ptr and moving upward with wrap; the first set bit wins.
//
// Ports:
//   req     in   NUM_REQ  request vector
//   rr_ptr  in   IDX_W    index to start the search from
//   winner  out  IDX_W    index of the winning requester (0 when none)
//   any_req out  1        at least one request is set
// ---------------------------------------------------------------------------
module cfg_rr_picker
    import switch_cfg_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    int j;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        j       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // Rotate the scan origin; rr_ptr is always < NUM_REQ, so one
            // subtraction is enough to wrap.
            j = int'(rr_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any_req && req[IDX_W'(j)]) begin
                any_req = 1'b1;
                winner  = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/switch_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// switch_cfg_arbiter
// Arbitrates NUM_REQ configuration requesters onto the single switch
// memory-config port. Three-state FSM: IDLE picks a round-robin winner and
// latches its operands, ACCESS drives the port until mem_ack, DONE pulses
// req_done to the winner and advances the round-robin pointer.
// Every output is registered.
//
// Optional feature macro: SWITCH_CFG_ARB_TIMEOUT_EN
//   defined   -> ACCESS aborts after TIMEOUT_CYC cycles without mem_ack,
//                completing with req_err=1 and req_rd_data=0.
//   undefined -> ACCESS waits for mem_ack forever, req_err is always 0.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   req                in   NUM_REQ      access request, held until done
//   req_wr_rd_s        in   NUM_REQ      direction per requester (1=write)
//   req_addr           in   NUM_REQ x 8  address per requester
//   req_wr_data        in   NUM_REQ x 8  write data per requester
//   req_done           out  NUM_REQ      one-cycle completion pulse
//   req_rd_data        out  8            read data, valid with req_done
//   req_err            out  1            timeout abort, valid with req_done
//   busy               out  1            FSM not in IDLE
//   mem_sel_en         out  1            port select, high during ACCESS
//   mem_wr_rd_s        out  1            port direction
//   mem_addr           out  8            port address
//   mem_wr_data        out  8            port write data
//   mem_rd_data        in   8            port read data
//   mem_ack            in   1            port acknowledge
// ---------------------------------------------------------------------------
module switch_cfg_arbiter
    import switch_cfg_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_wr_rd_s,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]             req_done,
    output logic [DATA_W-1:0]              req_rd_data,
    output logic                           req_err,
    output logic                           busy,
    output logic                           mem_sel_en,
    output logic                           mem_wr_rd_s,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wr_data,
    input  logic [DATA_W-1:0]              mem_rd_data,
    input  logic                           mem_ack
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   win_q;
    logic [IDX_W-1:0]   pick;
    logic               any_req;
    logic               grant;
    logic               timed_out;

    // Operands captured at grant; later requester changes are ignored.
    logic               op_wr;
    logic [ADDR_W-1:0]  op_addr;
    logic [DATA_W-1:0]  op_data;

    logic               sel_nxt;
    logic               wr_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic [NUM_REQ-1:0] done_nxt;
    logic [DATA_W-1:0]  rd_nxt;
    logic               err_nxt;

    cfg_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .winner  (pick),
        .any_req (any_req)
    );

`ifdef SWITCH_CFG_ARB_TIMEOUT_EN
    localparam int TO_W = idx_width(TIMEOUT_CYC);
    logic [TO_W-1:0] to_cnt;

    // Counts ACCESS cycles that ended without mem_ack; restarted at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (grant) begin
            to_cnt <= '0;
        end else if (state == ST_ACCESS) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timed_out = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign timed_out      = 1'b0;
`endif

    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead so they can all come straight from flops.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        sel_nxt   = 1'b0;
        wr_nxt    = 1'b0;
        addr_nxt  = '0;
        data_nxt  = '0;
        done_nxt  = '0;
        rd_nxt    = '0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_ACCESS;
                    grant     = 1'b1;
                    sel_nxt   = 1'b1;
                    wr_nxt    = req_wr_rd_s[pick];
                    addr_nxt  = req_addr[pick];
                    data_nxt  = req_wr_data[pick];
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    state_nxt       = ST_DONE;
                    done_nxt[win_q] = 1'b1;
                    rd_nxt          = op_wr ? '0 : mem_rd_data;
                end else if (timed_out) begin
                    state_nxt       = ST_DONE;
                    done_nxt[win_q] = 1'b1;
                    err_nxt         = 1'b1;
                end else begin
                    sel_nxt  = 1'b1;
                    wr_nxt   = op_wr;
                    addr_nxt = op_addr;
                    data_nxt = op_data;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            win_q   <= '0;
            op_wr   <= 1'b0;
            op_addr <= '0;
            op_data <= '0;
        end else begin
            if (grant) begin
                win_q   <= pick;
                op_wr   <= req_wr_rd_s[pick];
                op_addr <= req_addr[pick];
                op_data <= req_wr_data[pick];
            end
            if (state == ST_DONE) begin
                rr_ptr <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_sel_en  <= 1'b0;
            mem_wr_rd_s <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            req_done    <= '0;
            req_rd_data <= '0;
            req_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mem_sel_en  <= sel_nxt;
            mem_wr_rd_s <= wr_nxt;
            mem_addr    <= addr_nxt;
            mem_wr_data <= data_nxt;
            req_done    <= done_nxt;
            req_rd_data <= rd_nxt;
            req_err     <= err_nxt;
            busy        <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_switch_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_switch_cfg_arbiter
// Directed bench for switch_cfg_arbiter (NUM_REQ=4, TIMEOUT_CYC=16).
// Inputs change 1 time unit after a rising edge; outputs are checked at
// that same point, i.e. well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_switch_cfg_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     req_wr_rd_s;
    logic [N-1:0][7:0] req_addr;
    logic [N-1:0][7:0] req_wr_data;
    logic [N-1:0]     req_done;
    logic [7:0]       req_rd_data;
    logic             req_err;
    logic             busy;
    logic             mem_sel_en;
    logic             mem_wr_rd_s;
    logic [7:0]       mem_addr;
    logic [7:0]       mem_wr_data;
    logic [7:0]       mem_rd_data;
    logic             mem_ack;

    int vectors     = 0;
    int miscompares = 0;

    switch_cfg_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_wr_rd_s (req_wr_rd_s),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_done    (req_done),
        .req_rd_data (req_rd_data),
        .req_err     (req_err),
        .busy        (busy),
        .mem_sel_en  (mem_sel_en),
        .mem_wr_rd_s (mem_wr_rd_s),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sel"},  mem_sel_en, 0);
        chk({tag, "_wr"},   mem_wr_rd_s, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdat"}, mem_wr_data, 0);
        chk({tag, "_done"}, req_done, 0);
        chk({tag, "_rd"},   req_rd_data, 0);
        chk({tag, "_err"},  req_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_win [5];
        exp_win = '{0, 1, 2, 3, 0};

        rst_n       = 1'b0;
        req         = '0;
        req_wr_rd_s = '0;
        req_addr    = '0;
        req_wr_data = '0;
        mem_rd_data = '0;
        mem_ack     = 1'b0;

        // ---- reset state
        tick(); tick();
        chk_quiet("reset");
        rst_n = 1'b1;
        tick();

        // ---- write, requester 0, ack one cycle after select
        req[0] = 1'b1; req_wr_rd_s[0] = 1'b1; req_addr[0] = 8'h00; req_wr_data[0] = 8'h44;
        tick();
        chk("wr_sel1",  mem_sel_en, 1);
        chk("wr_dir1",  mem_wr_rd_s, 1);
        chk("wr_addr1", mem_addr, 8'h00);
        chk("wr_data1", mem_wr_data, 8'h44);
        chk("wr_busy1", busy, 1);
        chk("wr_done1", req_done, 0);
        tick();
        chk("wr_sel2",  mem_sel_en, 1);
        chk("wr_data2", mem_wr_data, 8'h44);
        mem_ack = 1'b1; mem_rd_data = 8'h99;
        tick();
        chk("wr_done",  req_done, 4'b0001);
        chk("wr_err",   req_err, 0);
        chk("wr_rd0",   req_rd_data, 0);
        chk("wr_sel3",  mem_sel_en, 0);
        chk("wr_busyD", busy, 1);
        mem_ack = 1'b0; mem_rd_data = 8'h00; req[0] = 1'b0;
        tick();
        chk_quiet("wr_idle");

        // ---- read, requester 2; operand change after grant is ignored
        req[2] = 1'b1; req_wr_rd_s[2] = 1'b0; req_addr[2] = 8'h10; req_wr_data[2] = 8'h77;
        tick();
        chk("rd_sel",  mem_sel_en, 1);
        chk("rd_dir",  mem_wr_rd_s, 0);
        chk("rd_addr", mem_addr, 8'h10);
        chk("rd_wdat", mem_wr_data, 8'h77);
        req_addr[2] = 8'hFF; req_wr_data[2] = 8'h11;
        tick();
        chk("rd_addr_hold", mem_addr, 8'h10);
        chk("rd_wdat_hold", mem_wr_data, 8'h77);
        mem_ack = 1'b1; mem_rd_data = 8'hA5;
        tick();
        chk("rd_done", req_done, 4'b0100);
        chk("rd_data", req_rd_data, 8'hA5);
        chk("rd_err",  req_err, 0);
        mem_ack = 1'b0; mem_rd_data = 8'h00; req[2] = 1'b0;
        tick();
        chk("rd_done_clr", req_done, 0);
        chk("rd_data_clr", req_rd_data, 0);

        // ---- req dropped during ACCESS; rr_ptr=3 so requester 1 wins via wrap
        req[1] = 1'b1; req_wr_rd_s[1] = 1'b1; req_addr[1] = 8'h22; req_wr_data[1] = 8'h33;
        tick();
        chk("drop_addr", mem_addr, 8'h22);
        req[1] = 1'b0;
        tick();
        chk("drop_sel", mem_sel_en, 1);
        mem_ack = 1'b1;
        tick();
        chk("drop_done", req_done, 4'b0010);
        mem_ack = 1'b0;
        tick();

        // ---- spurious ack while idle with no request
        mem_ack = 1'b1; mem_rd_data = 8'h5A;
        tick(); tick();
        chk_quiet("spur");
        mem_ack = 1'b0; mem_rd_data = 8'h00;

        // ---- all four held continuously from reset: order 0,1,2,3,0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_wr_rd_s = '0;
        for (int i = 0; i < N; i++) req_addr[i] = 8'h80 + 8'(i);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("rr_sel",  mem_sel_en, 1);
            chk("rr_addr", mem_addr, 8'h80 + exp_win[g]);
            mem_ack = 1'b1; mem_rd_data = 8'hC0 + 8'(g);
            tick();
            chk("rr_done", req_done, 1 << exp_win[g]);
            chk("rr_rd",   req_rd_data, 8'hC0 + g);
            chk("rr_sel_off", mem_sel_en, 0);
            mem_ack = 1'b0;
            if (g == 4) req = '0;
            tick();
            chk("rr_idle_busy", busy, 0);
            chk("rr_idle_sel",  mem_sel_en, 0);
        end
        req = '0;

        // ---- reset mid-ACCESS; rr_ptr=1 so requester 3 wins first
        req = 4'b1001;
        tick();
        chk("mid_addr", mem_addr, 8'h83);
        rst_n = 1'b0;
        #1;
        chk_quiet("mid_rst");
        tick();
        rst_n = 1'b1;
        chk("mid_nodone", req_done, 0);
        tick();
        chk("mid_regrant_sel",  mem_sel_en, 1);
        chk("mid_regrant_addr", mem_addr, 8'h80);
        mem_ack = 1'b1;
        tick();
        chk("mid_regrant_done", req_done, 4'b0001);
        mem_ack = 1'b0; req = '0;
        tick();

        // ---- no ack at all: 16 ACCESS cycles
        req[2] = 1'b1; req_addr[2] = 8'h10; mem_rd_data = 8'h5A;
        tick();
        repeat (15) tick();
        chk("to_sel16",  mem_sel_en, 1);
        chk("to_done16", req_done, 0);
`ifdef SWITCH_CFG_ARB_TIMEOUT_EN
        tick();
        chk("to_done", req_done, 4'b0100);
        chk("to_err",  req_err, 1);
        chk("to_rd",   req_rd_data, 0);
        chk("to_sel",  mem_sel_en, 0);
        req = '0;
        tick();
        chk("to_idle", busy, 0);
`else
        repeat (8) tick();
        chk("nto_busy", busy, 1);
        chk("nto_done", req_done, 0);
        chk("nto_sel",  mem_sel_en, 1);
        mem_ack = 1'b1;
        tick();
        chk("nto_late_done", req_done, 4'b0100);
        chk("nto_err",       req_err, 0);
        chk("nto_rd",        req_rd_data, 8'h5A);
        mem_ack = 1'b0; req = '0;
        tick();
        chk("nto_idle", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
